// File: rtl/bo_horner_datapath.sv
// Horner-rule datapath for y = a*x^2 + b*x + c, driven by per-cycle lx/ls/lh/h strobes.
// Optional BO_SAT_EN: saturate S (and y) to all-ones on overflow instead of wrapping.
module bo_horner_datapath #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lx,
  input  logic          ls,
  input  logic          lh,
  input  logic          h,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  coef_a,
  input  logic [W-1:0]  coef_b,
  input  logic [W-1:0]  coef_c,
  output logic [SW-1:0] y,
  output logic          y_valid,
  output logic          busy,
  output logic          ovf
);

  localparam int unsigned PW     = SW + W;
  localparam int unsigned SUMW   = SW + W + 1;
  localparam int unsigned KW     = 2;
  localparam int unsigned CNTW   = 2;
  localparam logic [KW-1:0]   K_LAST   = 2'd2;
  localparam logic [CNTW-1:0] CNT_DONE = 2'd2;
  localparam logic [CNTW-1:0] CNT_MAX  = 2'd3;

  logic [W-1:0]    x_q,       x_d;
  logic [SW-1:0]   s_q,       s_d;
  logic [W-1:0]    hr_q,      hr_d;
  logic [KW-1:0]   k_q,       k_d;
  logic [CNTW-1:0] ls_cnt_q,  ls_cnt_d;
  logic [SW-1:0]   y_q,       y_d;
  logic            y_valid_q, y_valid_d;
  logic            busy_q,    busy_d;
  logic            ovf_q,     ovf_d;

  logic [KW-1:0]   k_eff_c;
  logic [KW-1:0]   k_inc_c;
  logic [W-1:0]    coef_c_sel;
  logic [PW-1:0]   prod_c;
  logic [SUMW-1:0] sum_c;
  logic            sum_ovf_c;
  logic [SW-1:0]   s_step_c;

  // A new evaluation restarts coefficient indexing, so an lh alongside lx sees k=0.
  assign k_eff_c = lx ? '0 : k_q;
  assign k_inc_c = (k_eff_c >= K_LAST) ? K_LAST : KW'(k_eff_c + KW'(1));

  always_comb begin
    coef_c_sel = coef_c;
    case (k_eff_c)
      2'd0:    coef_c_sel = coef_a;
      2'd1:    coef_c_sel = coef_b;
      default: coef_c_sel = coef_c;
    endcase
  end

  // Full-precision Horner step; overflow is any bit above SW in the sum.
  assign prod_c    = PW'(s_q) * PW'(x_q);
  assign sum_c     = SUMW'(prod_c) + SUMW'(hr_q);
  assign sum_ovf_c = |sum_c[SUMW-1:SW];

`ifdef BO_SAT_EN
  assign s_step_c = sum_ovf_c ? {SW{1'b1}} : sum_c[SW-1:0];
`else
  assign s_step_c = sum_c[SW-1:0];
`endif

  always_comb begin
    x_d       = x_q;
    s_d       = s_q;
    hr_d      = hr_q;
    k_d       = k_q;
    ls_cnt_d  = ls_cnt_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    busy_d    = busy_q;
    ovf_d     = ovf_q;

    if (lx) begin
      x_d      = x_in;
      s_d      = '0;
      k_d      = '0;
      ls_cnt_d = '0;
      ovf_d    = 1'b0;
      busy_d   = 1'b1;
      if (lh) begin
        if (h) begin
          hr_d = coef_c_sel;
          k_d  = k_inc_c;
        end else begin
          hr_d = s_q[W-1:0];
        end
      end
    end else begin
      if (lh) begin
        if (h) begin
          hr_d = coef_c_sel;
          k_d  = k_inc_c;
        end else begin
          hr_d = s_q[W-1:0];
        end
      end
      if (ls) begin
        s_d = s_step_c;
        if (sum_ovf_c) begin
          ovf_d = 1'b1;
        end
        // Prefetch only when no explicit HR load competes this cycle.
        if (!h && !lh) begin
          hr_d = coef_c_sel;
          k_d  = k_inc_c;
        end
        if (ls_cnt_q != CNT_MAX) begin
          ls_cnt_d = CNTW'(ls_cnt_q + CNTW'(1));
        end
        if (ls_cnt_q == CNT_DONE) begin
          y_d       = s_step_c;
          y_valid_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      s_q       <= '0;
      hr_q      <= '0;
      k_q       <= '0;
      ls_cnt_q  <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      s_q       <= s_d;
      hr_q      <= hr_d;
      k_q       <= k_d;
      ls_cnt_q  <= ls_cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bo_horner_datapath.sv
// Directed + randomized bench for bo_horner_datapath against an integer reference model.
module tb_bo_horner_datapath;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 16;

  logic          clk;
  logic          rst;
  logic          lx, ls, lh, h;
  logic [W-1:0]  x_in, coef_a, coef_b, coef_c;
  logic [SW-1:0] y;
  logic          y_valid, busy, ovf;

  bo_horner_datapath #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .lx(lx), .ls(ls), .lh(lh), .h(h),
    .x_in(x_in), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .y(y), .y_valid(y_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference state as plain integers
  longint m_x, m_s, m_hr, m_k, m_cnt, m_y;
  bit     m_yv, m_busy, m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input longint exp);
    n_total++;
    assert (obs === 64'(exp)) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic longint coef_of(input longint k);
    if (k == 0) return longint'(coef_a);
    if (k == 1) return longint'(coef_b);
    return longint'(coef_c);
  endfunction

  task automatic model_edge(input bit r, input bit lx_, input bit ls_, input bit lh_, input bit h_);
    longint lim, full, ns, ke, nk, nhr;
    lim = longint'(1) << SW;
    if (r) begin
      m_x = 0; m_s = 0; m_hr = 0; m_k = 0; m_cnt = 0; m_y = 0;
      m_yv = 0; m_busy = 0; m_ovf = 0;
      return;
    end
    m_yv = 0;
    ke   = lx_ ? 0 : m_k;
    nk   = ke;
    nhr  = m_hr;
    if (lh_) begin
      if (h_) begin
        nhr = coef_of(ke);
        nk  = (ke >= 2) ? 2 : ke + 1;
      end else begin
        nhr = m_s % (longint'(1) << W);
      end
    end
    if (lx_) begin
      m_x = longint'(x_in); m_s = 0; m_cnt = 0; m_ovf = 0; m_busy = 1;
    end else if (ls_) begin
      full = m_s * m_x + m_hr;
      if (full >= lim) begin
        m_ovf = 1;
`ifdef BO_SAT_EN
        ns = lim - 1;
`else
        ns = full % lim;
`endif
      end else begin
        ns = full;
      end
      if (!h_ && !lh_) begin
        nhr = coef_of(ke);
        nk  = (ke >= 2) ? 2 : ke + 1;
      end
      if (m_cnt == 2) begin
        m_y = ns; m_yv = 1; m_busy = 0;
      end
      if (m_cnt < 3) m_cnt = m_cnt + 1;
      m_s = ns;
    end
    m_hr = nhr;
    m_k  = nk;
  endtask

  task automatic step(input string tag, input bit r, input bit lx_, input bit ls_,
                      input bit lh_, input bit h_);
    rst = r; lx = lx_; ls = ls_; lh = lh_; h = h_;
    @(posedge clk);
    model_edge(r, lx_, ls_, lh_, h_);
    #1;
    chk({tag, ".y"},       y,       m_y);
    chk({tag, ".y_valid"}, y_valid, longint'(m_yv));
    chk({tag, ".busy"},    busy,    longint'(m_busy));
    chk({tag, ".ovf"},     ovf,     longint'(m_ovf));
  endtask

  task automatic set_ops(input int xv, input int av, input int bv, input int cv);
    x_in = W'(xv); coef_a = W'(av); coef_b = W'(bv); coef_c = W'(cv);
  endtask

  // Nominal A..F control sequence
  task automatic run_seq(input string tag);
    step({tag, ".A"}, 0, 1, 0, 1, 1);
    step({tag, ".B"}, 0, 0, 1, 0, 1);
    step({tag, ".C"}, 0, 0, 0, 1, 1);
    step({tag, ".D"}, 0, 0, 1, 0, 0);
    step({tag, ".E"}, 0, 0, 1, 0, 0);
    step({tag, ".F"}, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clk = 0; rst = 1; lx = 0; ls = 0; lh = 0; h = 0;
    set_ops(0, 0, 0, 0);

    step("reset0", 1, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0);
    chk("reset_y", y, 0);

    set_ops(4, 2, 3, 5);
    run_seq("nominal");
    chk("nominal_y_const", y, 49);
    chk("nominal_ovf_const", ovf, 0);

    set_ops(255, 255, 255, 255);
    run_seq("ovf");
`ifdef BO_SAT_EN
    chk("ovf_y_const", y, 65535);
`else
    chk("ovf_y_const", y, 511);
`endif
    chk("ovf_flag_const", ovf, 1);
    step("ovf_clear_lx", 0, 1, 0, 0, 0);
    chk("ovf_cleared_const", ovf, 0);

    set_ops(3, 1, 2, 3);
    step("mid.A", 0, 1, 0, 1, 1);
    step("mid.B", 0, 0, 1, 0, 1);
    step("mid.C", 0, 0, 0, 1, 1);
    step("mid.rst", 1, 0, 0, 0, 0);
    chk("mid_rst_busy_const", busy, 0);
    set_ops(7, 1, 0, 0);
    run_seq("rerun");
    chk("rerun_y_const", y, 49);

    set_ops(1, 1, 1, 1);
    run_seq("b2b1");
    chk("b2b1_y_const", y, 3);
    set_ops(2, 1, 1, 1);
    run_seq("b2b2");
    chk("b2b2_y_const", y, 7);

    // lx with ls: ls must be ignored, so the full sequence still completes on the third ls
    set_ops(3, 2, 1, 4);
    step("sim.lxls", 0, 1, 1, 1, 1);
    step("sim.B", 0, 0, 1, 0, 1);
    step("sim.lsh0", 0, 0, 1, 1, 0);
    step("sim.C", 0, 0, 0, 1, 1);
    step("sim.D", 0, 0, 1, 0, 0);
    step("sim.idle", 0, 0, 0, 0, 0);

    set_ops(5, 1, 2, 3);
    run_seq("extra");
    step("extra.ls4", 0, 0, 1, 0, 1);
    step("extra.ls5", 0, 0, 1, 0, 0);
    chk("extra_y_const", y, 38);

    // Randomized strobes and operands
    for (int i = 0; i < 600; i++) begin
      int sel;
      set_ops($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
      sel = $urandom_range(99);
      step("rand", sel < 2, sel >= 2 && sel < 14, $urandom_range(1) == 1,
           $urandom_range(2) == 0, $urandom_range(1) == 1);
    end
    for (int i = 0; i < 20; i++) begin
      set_ops($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
      run_seq("rand_seq");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
